// File: rtl/port_ingress_buffer.sv
// ---------------------------------------------------------------------------
// port_ingress_buffer
//
// Per-port ingress stage of the 4-port switch. Incoming packets are queued in
// a FIFO. An arrival that finds the FIFO full is dropped, and the number of
// destinations it would have reached is added to a saturating drop counter.
// The head packet is offered to the crossbar arbiter as a mask of targets
// that are still waiting for a grant. The packet is retired only after every
// one of its targets has been granted, so a multicast packet can be served
// over several cycles.
//
// Parameters
//   DATA_W     payload width
//   ADDR_W     FIFO address width (depth = 2**ADDR_W)
//   NUM_PORTS  number of switch ports (width of target/req/grant masks)
//   CNT_W      drop counter width
//
// Ports
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_valid_in     ingress packet valid, one per cycle, no backpressure
//   i_source_in    source port id of the arriving packet
//   i_target_in    destination mask (one-hot or multicast)
//   i_data_in      payload of the arriving packet
//   i_grant_in     per-output grant from the arbiter for the current head
//   i_clr_stats    synchronous clear of the drop counter
//   o_req_out      head-packet targets still awaiting grant (registered)
//   o_pkt_source   source of the head packet (valid while requesting)
//   o_pkt_data     payload of the head packet (valid while requesting)
//   o_fifo_full    FIFO holds 2**ADDR_W packets
//   o_fifo_empty   FIFO holds no packets
//   o_level        FIFO occupancy
//   o_drop_count   saturating count of dropped destinations
// ---------------------------------------------------------------------------
module port_ingress_buffer #(
   parameter int DATA_W    = 8,
   parameter int ADDR_W    = 4,
   parameter int NUM_PORTS = 4,
   parameter int CNT_W     = 16
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic                 i_valid_in,
   input  logic [1:0]           i_source_in,
   input  logic [NUM_PORTS-1:0] i_target_in,
   input  logic [DATA_W-1:0]    i_data_in,
   input  logic [NUM_PORTS-1:0] i_grant_in,
   input  logic                 i_clr_stats,
   output logic [NUM_PORTS-1:0] o_req_out,
   output logic [1:0]           o_pkt_source,
   output logic [DATA_W-1:0]    o_pkt_data,
   output logic                 o_fifo_full,
   output logic                 o_fifo_empty,
   output logic [ADDR_W:0]      o_level,
   output logic [CNT_W-1:0]     o_drop_count
);

   localparam int               DEPTH    = 1 << ADDR_W;
   localparam int               ENTRY_W  = 2 + NUM_PORTS + DATA_W;
   localparam logic [ADDR_W:0]  LEVEL_MAX = (ADDR_W+1)'(DEPTH);
   localparam logic [CNT_W:0]   CNT_MAX   = {1'b0, {CNT_W{1'b1}}};

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   logic [ENTRY_W-1:0]   r_mem [DEPTH];
   logic [ADDR_W-1:0]    r_wrPtr;
   logic [ADDR_W-1:0]    r_rdPtr;
   logic [ADDR_W:0]      r_level;
   logic [CNT_W-1:0]     r_dropCount;
   logic [NUM_PORTS-1:0] r_remaining;
   state_t               r_state;

   logic                 w_full;
   logic                 w_empty;
   logic                 w_write;
   logic                 w_drop;
   logic                 w_pop;
   logic [ENTRY_W-1:0]   w_head;
   logic [NUM_PORTS-1:0] w_headTarget;
   logic [NUM_PORTS-1:0] w_stillNeeded;
   logic [CNT_W:0]       w_dropOnes;
   logic [CNT_W:0]       w_cntBase;
   logic [CNT_W:0]       w_cntSum;
   logic [CNT_W-1:0]     w_cntNext;

   // Full/empty come from the registered level, so an arrival at the same
   // edge as a pop still sees the FIFO as full and is dropped.
   assign w_full  = (r_level == LEVEL_MAX);
   assign w_empty = (r_level == '0);

   // An all-zero target mask has nowhere to go; it is neither stored nor
   // counted as a drop.
   assign w_write = i_valid_in && !w_full && (i_target_in != '0);
   assign w_drop  = i_valid_in && w_full;

   assign w_head        = r_mem[r_rdPtr];
   assign w_headTarget  = w_head[DATA_W +: NUM_PORTS];
   assign w_stillNeeded = r_remaining & ~i_grant_in;

   // The head retires once the last outstanding target has been granted.
   assign w_pop = (r_state == ACTIVE) && (w_stillNeeded == '0);

   // Number of destinations carried by the arriving packet.
   always_comb begin
      w_dropOnes = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         w_dropOnes = w_dropOnes + (CNT_W+1)'(i_target_in[i]);
      end
   end

   // Counter update: a clear wipes the old total but still keeps a drop
   // seen at the same edge, and the sum clips at the all-ones value.
   always_comb begin
      w_cntBase = i_clr_stats ? '0 : {1'b0, r_dropCount};
      w_cntSum  = w_cntBase + (w_drop ? w_dropOnes : '0);
      w_cntNext = (w_cntSum > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : w_cntSum[CNT_W-1:0];
   end

   // Packet storage. It has no reset: stale entries are never visible
   // because the outputs are gated by the head state and the level.
   always_ff @(posedge i_clk) begin
      if (w_write) begin
         r_mem[r_wrPtr] <= {i_source_in, i_target_in, i_data_in};
      end
   end

   // FIFO pointers and occupancy. A write and a pop at the same edge leave
   // the level unchanged. The pointers wrap naturally at the depth.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_level <= '0;
      end else begin
         if (w_write) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         if (w_write && !w_pop) begin
            r_level <= r_level + 1'b1;
         end else if (!w_write && w_pop) begin
            r_level <= r_level - 1'b1;
         end
      end
   end

   // Saturating drop statistics.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dropCount <= '0;
      end else begin
         r_dropCount <= w_cntNext;
      end
   end

   // Head FSM. r_remaining is held at zero in IDLE, so it doubles as the
   // registered request mask. Grant bits outside the mask have no effect.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= IDLE;
         r_remaining <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_remaining <= w_headTarget;
                  r_state     <= ACTIVE;
               end
            end
            ACTIVE: begin
               r_remaining <= w_stillNeeded;
               if (w_pop) begin
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_remaining <= '0;
            end
         endcase
      end
   end

   assign o_req_out    = r_remaining;
   assign o_pkt_source = (r_state == ACTIVE) ? w_head[ENTRY_W-1 -: 2] : 2'b00;
   assign o_pkt_data   = (r_state == ACTIVE) ? w_head[DATA_W-1:0] : '0;
   assign o_fifo_full  = w_full;
   assign o_fifo_empty = w_empty;
   assign o_level      = r_level;
   assign o_drop_count = r_dropCount;

endmodule

// File: tb/tb_port_ingress_buffer.sv
// ---------------------------------------------------------------------------
// tb_port_ingress_buffer
//
// Self-checking bench for port_ingress_buffer. The drop counter is narrowed
// to 4 bits so that saturation can be reached in a few cycles. Expected
// outputs come from a packet-queue reference model that follows the
// buffering, request and drop rules directly.
// ---------------------------------------------------------------------------
module tb_port_ingress_buffer;

   localparam int DATA_W    = 8;
   localparam int ADDR_W    = 4;
   localparam int NUM_PORTS = 4;
   localparam int CNT_W     = 4;
   localparam int DEPTH     = 16;
   localparam int CNT_MAX   = 15;

   typedef struct packed {
      logic [1:0] src;
      logic [3:0] tgt;
      logic [7:0] data;
   } pkt_t;

   logic                 clk;
   logic                 rstN;
   logic                 validIn;
   logic [1:0]           sourceIn;
   logic [NUM_PORTS-1:0] targetIn;
   logic [DATA_W-1:0]    dataIn;
   logic [NUM_PORTS-1:0] grantIn;
   logic                 clrStats;
   logic [NUM_PORTS-1:0] reqOut;
   logic [1:0]           pktSource;
   logic [DATA_W-1:0]    pktData;
   logic                 fifoFull;
   logic                 fifoEmpty;
   logic [ADDR_W:0]      level;
   logic [CNT_W-1:0]     dropCount;

   int checks = 0;
   int errors = 0;

   // Reference model state: the queued packets, whether the head is being
   // served, which of its targets are still outstanding, and the drop total.
   pkt_t       q[$];
   bit         mActive;
   logic [3:0] mRem;
   int         mCount;

   port_ingress_buffer #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_PORTS(NUM_PORTS),
      .CNT_W    (CNT_W)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rstN),
      .i_valid_in  (validIn),
      .i_source_in (sourceIn),
      .i_target_in (targetIn),
      .i_data_in   (dataIn),
      .i_grant_in  (grantIn),
      .i_clr_stats (clrStats),
      .o_req_out   (reqOut),
      .o_pkt_source(pktSource),
      .o_pkt_data  (pktData),
      .o_fifo_full (fifoFull),
      .o_fifo_empty(fifoEmpty),
      .o_level     (level),
      .o_drop_count(dropCount)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Wipe the model the way an asynchronous reset wipes the design.
   task automatic modelReset();
      q.delete();
      mActive = 1'b0;
      mRem    = 4'b0000;
      mCount  = 0;
   endtask

   // Advance the model by one clock edge, using the values held before the edge.
   task automatic modelStep(input logic v, input logic [1:0] s, input logic [3:0] t,
                            input logic [7:0] d, input logic [3:0] g, input logic c);
      bit wasFull;
      bit hadPacket;
      int total;
      wasFull   = (q.size() == DEPTH);
      hadPacket = (q.size() != 0);
      if (mActive) begin
         mRem = mRem & ~g;
         if (mRem == 4'b0000) begin
            void'(q.pop_front());
            mActive = 1'b0;
         end
      end else if (hadPacket) begin
         mRem    = q[0].tgt;
         mActive = 1'b1;
      end
      if (v && !wasFull && t != 4'b0000) begin
         q.push_back({s, t, d});
      end
      total = c ? 0 : mCount;
      if (v && wasFull) begin
         total = total + $countones(t);
      end
      mCount = (total > CNT_MAX) ? CNT_MAX : total;
   endtask

   // Compare every DUT output with what the model predicts.
   task automatic checkOutput(input string tag);
      logic [3:0] expReq;
      logic [1:0] expSrc;
      logic [7:0] expData;
      expReq  = mActive ? mRem : 4'b0000;
      expSrc  = mActive ? q[0].src : 2'b00;
      expData = mActive ? q[0].data : 8'h00;

      checks++;
      assert (reqOut === expReq) else begin
         errors++;
         $error("[TB] FAIL %s.req_out observed=%b expected=%b", tag, reqOut, expReq);
      end
      checks++;
      assert (pktSource === expSrc) else begin
         errors++;
         $error("[TB] FAIL %s.pkt_source observed=%0d expected=%0d", tag, pktSource, expSrc);
      end
      checks++;
      assert (pktData === expData) else begin
         errors++;
         $error("[TB] FAIL %s.pkt_data observed=%h expected=%h", tag, pktData, expData);
      end
      checks++;
      assert (level === 5'(q.size())) else begin
         errors++;
         $error("[TB] FAIL %s.level observed=%0d expected=%0d", tag, level, q.size());
      end
      checks++;
      assert (fifoFull === (q.size() == DEPTH)) else begin
         errors++;
         $error("[TB] FAIL %s.fifo_full observed=%b expected=%b", tag, fifoFull, q.size() == DEPTH);
      end
      checks++;
      assert (fifoEmpty === (q.size() == 0)) else begin
         errors++;
         $error("[TB] FAIL %s.fifo_empty observed=%b expected=%b", tag, fifoEmpty, q.size() == 0);
      end
      checks++;
      assert (dropCount === 4'(mCount)) else begin
         errors++;
         $error("[TB] FAIL %s.drop_count observed=%0d expected=%0d", tag, dropCount, mCount);
      end
   endtask

   // Drive one cycle of inputs, step the model for the coming edge, and check
   // the outputs on the following falling edge.
   task automatic applyStimulus(input logic v, input logic [1:0] s, input logic [3:0] t,
                                input logic [7:0] d, input logic [3:0] g, input logic c,
                                input string tag);
      validIn  = v;
      sourceIn = s;
      targetIn = t;
      dataIn   = d;
      grantIn  = g;
      clrStats = c;
      modelStep(v, s, t, d, g, c);
      @(posedge clk);
      @(negedge clk);
      checkOutput(tag);
   endtask

   // Spot check of a single value against a constant taken from the test plan.
   task automatic checkValue(input string tag, input int observed, input int expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   initial begin
      logic [3:0] rt;
      logic [3:0] rg;

      rstN     = 1'b0;
      validIn  = 1'b0;
      sourceIn = 2'b00;
      targetIn = 4'b0000;
      dataIn   = 8'h00;
      grantIn  = 4'b0000;
      clrStats = 1'b0;
      modelReset();

      // Reset state.
      repeat (3) @(negedge clk);
      checkOutput("reset");
      rstN = 1'b1;
      @(negedge clk);
      checkOutput("afterReset");

      // Single unicast packet: visible after E0, requesting after E1, retired on grant.
      applyStimulus(1'b1, 2'd1, 4'b0100, 8'hA5, 4'b0000, 1'b0, "uniWrite");
      applyStimulus(1'b0, 2'd0, 4'b0000, 8'h00, 4'b0000, 1'b0, "uniLoad");
      checkValue("uniReq", int'(reqOut), 4);
      checkValue("uniData", int'(pktData), 8'hA5);
      applyStimulus(1'b0, 2'd0, 4'b0000, 8'h00, 4'b0100, 1'b0, "uniGrant");
      checkValue("uniPopLevel", int'(level), 0);

      // Multicast head served over three grant cycles.
      applyStimulus(1'b1, 2'd2, 4'b1011, 8'h3C, 4'b0000, 1'b0, "mcWrite");
      applyStimulus(1'b0, 2'd0, 4'b0000, 8'h00, 4'b0000, 1'b0, "mcLoad");
      checkValue("mcReq0", int'(reqOut), 4'b1011);
      applyStimulus(1'b0, 2'd0, 4'b0000, 8'h00, 4'b0001, 1'b0, "mcGrant1");
      checkValue("mcReq1", int'(reqOut), 4'b1010);
      applyStimulus(1'b0, 2'd0, 4'b0000, 8'h00, 4'b1000, 1'b0, "mcGrant2");
      checkValue("mcReq2", int'(reqOut), 4'b0010);
      applyStimulus(1'b0, 2'd0, 4'b0000, 8'h00, 4'b0010, 1'b0, "mcGrant3");
      checkValue("mcPopReq", int'(reqOut), 0);

      // Fill to capacity with no grants, then three arrivals that are dropped.
      for (int i = 0; i < DEPTH; i++) begin
         applyStimulus(1'b1, 2'($urandom_range(0, 3)), 4'($urandom_range(1, 15)),
                       8'($urandom), 4'b0000, 1'b0, "fill");
      end
      checkValue("fillFull", int'(fifoFull), 1);
      applyStimulus(1'b1, 2'd0, 4'b0111, 8'h11, 4'b0000, 1'b0, "drop1");
      applyStimulus(1'b1, 2'd0, 4'b0001, 8'h22, 4'b0000, 1'b0, "drop2");
      applyStimulus(1'b1, 2'd0, 4'b1111, 8'h33, 4'b0000, 1'b0, "drop3");
      checkValue("dropCount8", int'(dropCount), 8);
      checkValue("dropLevel16", int'(level), 16);

      // Arrival at the same edge as the pop that frees a slot is still dropped.
      applyStimulus(1'b1, 2'd3, 4'b0011, 8'h44, 4'b1111, 1'b0, "dropAtPop");
      checkValue("dropAtPopCount", int'(dropCount), 10);
      checkValue("dropAtPopLevel", int'(level), 15);

      // Bring the counter to 14, saturate at 15, then clear alongside a drop.
      applyStimulus(1'b0, 2'd0, 4'b0000, 8'h00, 4'b0000, 1'b1, "clear");
      applyStimulus(1'b1, 2'd1, 4'b0001, 8'h55, 4'b0000, 1'b0, "refill");
      applyStimulus(1'b1, 2'd0, 4'b1111, 8'h00, 4'b0000, 1'b0, "sat1");
      applyStimulus(1'b1, 2'd0, 4'b1111, 8'h00, 4'b0000, 1'b0, "sat2");
      applyStimulus(1'b1, 2'd0, 4'b1111, 8'h00, 4'b0000, 1'b0, "sat3");
      applyStimulus(1'b1, 2'd0, 4'b0011, 8'h00, 4'b0000, 1'b0, "sat4");
      checkValue("count14", int'(dropCount), 14);
      applyStimulus(1'b1, 2'd0, 4'b1111, 8'h00, 4'b0000, 1'b0, "satTop");
      checkValue("count15", int'(dropCount), 15);
      applyStimulus(1'b1, 2'd0, 4'b0011, 8'h00, 4'b0000, 1'b1, "clrWithDrop");
      checkValue("clrWithDropCount", int'(dropCount), 2);

      // Free a slot, then offer a packet with no targets: nothing changes.
      applyStimulus(1'b0, 2'd0, 4'b0000, 8'h00, 4'b1111, 1'b0, "freeSlot");
      applyStimulus(1'b1, 2'd2, 4'b0000, 8'h77, 4'b0000, 1'b0, "zeroTarget");
      checkValue("zeroTargetLevel", int'(level), 15);
      checkValue("zeroTargetCount", int'(dropCount), 2);

      // Randomized traffic, with grants, clears and occasional overflow.
      for (int i = 0; i < 400; i++) begin
         rt = 4'($urandom);
         rg = 4'($urandom);
         applyStimulus(1'(($urandom % 4) != 0), 2'($urandom), rt, 8'($urandom),
                       (i % 100 < 50) ? rg : 4'b0000, 1'(($urandom % 32) == 0), "rand");
      end

      // Asynchronous reset while serving a head with five packets queued.
      rstN = 1'b0;
      modelReset();
      @(negedge clk);
      rstN = 1'b1;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 2'($urandom), 4'($urandom_range(1, 15)), 8'($urandom),
                       4'b0000, 1'b0, "preReset");
      end
      applyStimulus(1'b0, 2'd0, 4'b0000, 8'h00, 4'b0000, 1'b0, "preResetIdle");
      checkValue("preResetLevel", int'(level), 5);
      #2;
      rstN = 1'b0;
      modelReset();
      #1;
      checkOutput("asyncReset");
      @(negedge clk);
      rstN = 1'b1;
      applyStimulus(1'b0, 2'd0, 4'b0000, 8'h00, 4'b0000, 1'b0, "postReset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
